typing_test_ctrl: RTL and testbench

Sequencing controller for the keypad typing test. It consumes key events from the keypad scanner (key code plus held-key level) and generates a pseudo-random target digit sequence. It compares each new keypress against the current target, keeps correct and error counts and elapsed seconds, and ends the run on sequence completion or timeout. Its outputs drive the display and scoring logic.

---
 rtl/typing_pkg.sv | 27 ++
 rtl/typing_test_ctrl_if.sv | 26 ++
 rtl/typing_target_gen.sv | 27 ++
 rtl/typing_test_ctrl.sv | 99 +++++++++
 tb/tb_typing_test_ctrl.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/typing_pkg.sv
// Shared types and helpers for the keypad typing-test controller.
package typing_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;
  // Fibonacci taps at bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

  // Fold the 4-bit LFSR nibble onto 0..9
  function automatic logic [3:0] digit_map(input logic [3:0] n);
    return (n < 4'd10) ? n : n - 4'd6;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/typing_test_ctrl_if.sv
// Key input and score/display outputs of the typing-test controller.
interface typing_test_ctrl_if;
  logic       start;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] target_digit;
  logic [4:0] target_index;
  logic [7:0] correct_cnt;
  logic [7:0] error_cnt;
  logic [7:0] seconds;
  logic [1:0] state;
  logic       done;
  logic       key_accept;

  modport master (
    output start, key_valid, key_code,
    input  target_digit, target_index, correct_cnt, error_cnt, seconds,
           state, done, key_accept
  );

  modport slave (
    input  start, key_valid, key_code,
    output target_digit, target_index, correct_cnt, error_cnt, seconds,
           state, done, key_accept
  );
endinterface

// File: rtl/typing_target_gen.sv
// LFSR-driven target digit source; the mapped digit is registered with the LFSR.
module typing_target_gen
  import typing_pkg::*;
(
  input  logic       clk,
  input  logic       load,
  input  logic       advance,
  input  logic [7:0] seed,
  output logic [3:0] target_digit
);

  logic [7:0] lfsr;
  logic [7:0] lfsr_nx;

  always_comb lfsr_nx = lfsr_next(lfsr);

  always_ff @(posedge clk) begin
    if (load) begin
      lfsr         <= seed;
      target_digit <= digit_map(seed[3:0]);
    end else if (advance) begin
      lfsr         <= lfsr_nx;
      target_digit <= digit_map(lfsr_nx[3:0]);
    end
  end

endmodule

// File: rtl/typing_test_ctrl.sv
// Typing-test sequencer: key edge detect, run FSM, elapsed-second timer and scoring.
module typing_test_ctrl
  import typing_pkg::*;
#(
  parameter int         SEQ_LEN    = 16,
  parameter int         TICK_DIV   = 100_000_000,
  parameter int         TIME_LIMIT = 60,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input logic               clk,
  input logic               rst,
  typing_test_ctrl_if.slave bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t        state_q, state_d;
  logic          done_q, accept_q, prev_valid;
  logic [TW-1:0] tick_q;
  logic [4:0]    idx_q;
  logic [7:0]    corr_q, err_q, sec_q;
  logic [3:0]    target;
  logic          key_event, is_digit, hit, at_end, tick_wrap;
  logic          run_start, scoring, tick_en;

  assign key_event = bus.key_valid & ~prev_valid;
  assign is_digit  = bus.key_code <= KEY_MAX_DIGIT;
  assign hit       = bus.key_code == target;
  assign at_end    = (idx_q == 5'(SEQ_LEN)) || (sec_q == 8'(TIME_LIMIT));
  assign tick_wrap = tick_en && (tick_q == TW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (at_end)    state_d = DONE;
      DONE:    if (bus.start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // A press landing on the timeout cycle still scores; the index limit blocks overshoot.
  always_comb begin
    run_start = bus.start && (state_q != RUN);
    scoring   = (state_q == RUN) && key_event && is_digit && (idx_q != 5'(SEQ_LEN));
    tick_en   = (state_q == RUN) && (sec_q != 8'(TIME_LIMIT));
  end

  always_ff @(posedge clk) begin
    prev_valid <= rst ? 1'b0 : bus.key_valid;
    accept_q   <= rst ? 1'b0 : scoring;
    if (rst || run_start) begin
      tick_q <= '0;
      idx_q  <= '0;
      corr_q <= '0;
      err_q  <= '0;
      sec_q  <= '0;
    end else begin
      if (tick_en) tick_q <= tick_wrap ? '0 : tick_q + TW'(1);
      if (tick_wrap) sec_q <= sat_inc(sec_q);
      if (scoring) begin
        if (hit) begin
          corr_q <= sat_inc(corr_q);
          idx_q  <= idx_q + 5'd1;
        end else begin
          err_q  <= sat_inc(err_q);
        end
      end
    end
  end

  typing_target_gen u_gen (
    .clk          (clk),
    .load         (rst || run_start),
    .advance      (scoring && hit),
    .seed         (LFSR_SEED),
    .target_digit (target)
  );

  assign bus.target_digit = target;
  assign bus.target_index = idx_q;
  assign bus.correct_cnt  = corr_q;
  assign bus.error_cnt    = err_q;
  assign bus.seconds      = sec_q;
  assign bus.state        = state_q;
  assign bus.done         = done_q;
  assign bus.key_accept   = accept_q;

endmodule

// File: tb/tb_typing_test_ctrl.sv
// Directed bench: DUT a (long run, slow tick) and DUT b (SEQ_LEN 2, fast timeout).
module tb_typing_test_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  typing_test_ctrl_if ia();
  typing_test_ctrl_if ib();

  typing_test_ctrl #(.SEQ_LEN(16), .TICK_DIV(1000), .TIME_LIMIT(60), .LFSR_SEED(8'hA5))
    dut_a (.clk(clk), .rst(rst), .bus(ia));
  typing_test_ctrl #(.SEQ_LEN(2), .TICK_DIV(10), .TIME_LIMIT(3), .LFSR_SEED(8'hA5))
    dut_b (.clk(clk), .rst(rst), .bus(ib));

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) ib.start = 1'b1; else ia.start = 1'b1;
    step(1);
    ib.start = 1'b0;
    ia.start = 1'b0;
  endtask

  // Hold a key for 'hold' cycles, release, and count key_accept pulses seen.
  task automatic press(input bit sel, input logic [3:0] code, input int hold, output int acc);
    acc = 0;
    if (sel) begin ib.key_code = code; ib.key_valid = 1'b1; end
    else     begin ia.key_code = code; ia.key_valid = 1'b1; end
    repeat (hold) begin
      @(negedge clk);
      if ((sel ? ib.key_accept : ia.key_accept) === 1'b1) acc++;
    end
    ia.key_valid = 1'b0;
    ib.key_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if ((sel ? ib.key_accept : ia.key_accept) === 1'b1) acc++;
    end
  endtask

  initial begin
    int acc;
    int cnt;
    ia.start = 0; ia.key_valid = 1; ia.key_code = 4'd5;
    ib.start = 0; ib.key_valid = 0; ib.key_code = 4'd0;

    // reset with key already held: no event, reset values
    step(3);
    rst = 1'b0;
    acc = 0;
    repeat (5) begin @(negedge clk); if (ia.key_accept === 1'b1) acc++; end
    chk("rst_accept", acc, 0);
    chk("rst_state", ia.state, 0);
    chk("rst_target", ia.target_digit, 5);
    chk("rst_correct", ia.correct_cnt, 0);
    chk("rst_error", ia.error_cnt, 0);
    chk("rst_index", ia.target_index, 0);
    chk("rst_seconds", ia.seconds, 0);
    chk("rst_done", ia.done, 0);
    ia.key_valid = 0;
    step(2);

    // idle ignores keys
    press(0, 4'd5, 3, acc);
    chk("idle_accept", acc, 0);
    chk("idle_correct", ia.correct_cnt, 0);

    pulse_start(0);
    chk("run_state", ia.state, 1);
    press(0, 4'd5, 50, acc);
    chk("held_accept_once", acc, 1);
    chk("hit_correct", ia.correct_cnt, 1);
    chk("hit_index", ia.target_index, 1);
    chk("hit_next_target", ia.target_digit, 4);

    press(0, 4'd7, 3, acc);
    chk("miss_accept", acc, 1);
    chk("miss_error", ia.error_cnt, 1);
    chk("miss_target", ia.target_digit, 4);
    chk("miss_index", ia.target_index, 1);

    press(0, 4'hC, 3, acc);
    chk("nondigit_accept", acc, 0);
    chk("nondigit_error", ia.error_cnt, 1);
    chk("nondigit_correct", ia.correct_cnt, 1);

    press(0, 4'd4, 3, acc);
    chk("hit2_target", ia.target_digit, 5);
    press(0, 4'd5, 3, acc);
    chk("hit3_correct", ia.correct_cnt, 3);
    chk("hit3_index", ia.target_index, 3);
    chk("hit3_target", ia.target_digit, 4);

    // start while running is ignored
    pulse_start(0);
    chk("restart_ignored", ia.correct_cnt, 3);
    chk("restart_state", ia.state, 1);

    // reset mid-run
    rst = 1'b1;
    step(1);
    chk("mid_rst_state", ia.state, 0);
    chk("mid_rst_correct", ia.correct_cnt, 0);
    chk("mid_rst_error", ia.error_cnt, 0);
    chk("mid_rst_index", ia.target_index, 0);
    chk("mid_rst_target", ia.target_digit, 5);
    chk("mid_rst_accept", ia.key_accept, 0);
    rst = 1'b0;
    step(1);
    pulse_start(0);
    press(0, 4'd5, 3, acc);
    chk("rerun_correct", ia.correct_cnt, 1);
    chk("rerun_target", ia.target_digit, 4);

    // b: sequence completion
    pulse_start(1);
    press(1, 4'd5, 3, acc);
    press(1, 4'd4, 3, acc);
    chk("seq_state", ib.state, 2);
    chk("seq_done", ib.done, 1);
    chk("seq_correct", ib.correct_cnt, 2);
    press(1, 4'd3, 3, acc);
    chk("done_accept", acc, 0);
    chk("done_error", ib.error_cnt, 0);
    chk("done_correct", ib.correct_cnt, 2);

    // b: timeout with a correct press on the timeout cycle
    pulse_start(1);
    chk("to_restart_state", ib.state, 1);
    chk("to_restart_correct", ib.correct_cnt, 0);
    cnt = 0;
    while (ib.seconds !== 8'd3 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("to_cycles", cnt, 30);
    chk("to_state_run", ib.state, 1);
    ib.key_code = 4'd5;
    ib.key_valid = 1'b1;
    step(1);
    chk("to_accept", ib.key_accept, 1);
    chk("to_correct", ib.correct_cnt, 1);
    chk("to_state_done", ib.state, 2);
    ib.key_valid = 1'b0;
    step(20);
    chk("to_seconds_frozen", ib.seconds, 3);
    chk("to_done", ib.done, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
